// File: rtl/ex_muldiv_unit.sv
// -----------------------------------------------------------------------------
// ex_muldiv_unit
//   Iterative RV64M multiply/divide unit for the EX stage. Consumes the
//   registered opcode/func3/func7 and the forwarded operands, retires one
//   multiplier or quotient bit per cycle, and hands a registered result plus a
//   one-cycle completion pulse to the EX/MEM register. stall_req holds the
//   front of the pipe while an operation is being accepted or is iterating.
//
//   Optional feature macro: MULDIV_FLUSH_EN
//     defined   : adds input 'flush'. It aborts any operation at the next edge,
//                 suppresses its result_valid and keeps the previous result.
//     undefined : no flush port; every accepted operation runs to completion.
//
// Ports
//   clk           in   clock, all state on the rising edge
//   reset         in   asynchronous, active-low reset
//   start         in   EX holds a valid instruction this cycle
//   flush         in   (MULDIV_FLUSH_EN only) abort current operation
//   alu_op_in     in   0110011 = OP, 0111011 = OP-32 (W variants)
//   alu_func3_in  in   MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//   alu_func7_in  in   0000001 selects the M extension
//   operand_a     in   rs1 (multiplicand / dividend)
//   operand_b     in   rs2 (multiplier / divisor)
//   busy          out  unit is iterating
//   stall_req     out  busy | accept
//   result_valid  out  one-cycle completion pulse
//   result        out  final result, held until the next completion
// -----------------------------------------------------------------------------
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no operation in flight, ready to accept
//   MUL     | shift-add multiply, one multiplier bit per edge
//   DIV     | restoring divide, one quotient bit per edge
//   DONE    | result_valid high; may accept the next operation this cycle
// -----------------------------------------------------------------------------
module ex_muldiv_unit #(
    parameter int XLEN            = 64,
    parameter int ALU_OP_WIDTH    = 7,
    parameter int ALU_FUNC3_WIDTH = 3,
    parameter int ALU_FUNC7_WIDTH = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
`ifdef MULDIV_FLUSH_EN
    input  logic                       flush,
`endif
    input  logic [ALU_OP_WIDTH-1:0]    alu_op_in,
    input  logic [ALU_FUNC3_WIDTH-1:0] alu_func3_in,
    input  logic [ALU_FUNC7_WIDTH-1:0] alu_func7_in,
    input  logic [XLEN-1:0]            operand_a,
    input  logic [XLEN-1:0]            operand_b,
    output logic                       busy,
    output logic                       stall_req,
    output logic                       result_valid,
    output logic [XLEN-1:0]            result
);

    localparam int CNT_W = $clog2(XLEN + 1);

    localparam logic [ALU_OP_WIDTH-1:0]    OPC_OP   = ALU_OP_WIDTH'(7'b0110011);
    localparam logic [ALU_OP_WIDTH-1:0]    OPC_OP32 = ALU_OP_WIDTH'(7'b0111011);
    localparam logic [ALU_FUNC7_WIDTH-1:0] F7_M     = ALU_FUNC7_WIDTH'(7'b0000001);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
        return {{(XLEN-32){1'b0}}, v};
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    counter_q, counter_d;
    logic [2:0]          f3_q, f3_d;
    logic                is_w_q, is_w_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic [XLEN-1:0]     ma_q, ma_d;       // multiplicand / divisor magnitude
    logic [XLEN-1:0]     mb_q, mb_d;       // multiplier / dividend -> quotient
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                result_valid_q, result_valid_d;

    // -------------------------------------------------------------------------
    // Decode of the incoming instruction
    // -------------------------------------------------------------------------
    logic [2:0] f3_in;
    logic       is_op, is_op32, is_m, can_accept, accept;
    logic       a_signed, b_signed;

    assign f3_in      = alu_func3_in[2:0];
    assign is_op      = (alu_op_in == OPC_OP);
    assign is_op32    = (alu_op_in == OPC_OP32);
    // OP-32 only carries MULW and the four divides.
    assign is_m       = (alu_func7_in == F7_M) &&
                        (is_op || (is_op32 && ((f3_in == 3'b000) || f3_in[2])));
    assign can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept     = start && is_m && can_accept;

    // MUL and MULHU need no sign handling; MULHSU signs only rs1.
    assign a_signed = (f3_in == 3'b001) || (f3_in == 3'b010) || (f3_in[2] && !f3_in[0]);
    assign b_signed = (f3_in == 3'b001) || (f3_in[2] && !f3_in[0]);

    // -------------------------------------------------------------------------
    // Operand preparation
    // -------------------------------------------------------------------------
    logic [XLEN-1:0] a_eff, b_eff, mag_a, mag_b, min_eff;
    logic            neg_a, neg_b;
    logic            b_zero, div_ovf, fast;
    logic [XLEN-1:0] fast_raw, fast_res;

    assign a_eff = is_op32 ? (a_signed ? sext32(operand_a[31:0]) : zext32(operand_a[31:0]))
                           : operand_a;
    assign b_eff = is_op32 ? (b_signed ? sext32(operand_b[31:0]) : zext32(operand_b[31:0]))
                           : operand_b;

    assign neg_a = a_signed && a_eff[XLEN-1];
    assign neg_b = b_signed && b_eff[XLEN-1];
    assign mag_a = neg_a ? (-a_eff) : a_eff;
    assign mag_b = neg_b ? (-b_eff) : b_eff;

    assign min_eff = is_op32 ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign b_zero  = (b_eff == '0);
    assign div_ovf = b_signed && (a_eff == min_eff) && (&b_eff);
    assign fast    = f3_in[2] && (b_zero || div_ovf);

    // Divide-by-zero and MIN/-1 are resolved without iterating.
    assign fast_raw = f3_in[1] ? (b_zero ? a_eff : '0)
                               : (b_zero ? '1    : a_eff);
    assign fast_res = is_op32 ? sext32(fast_raw[31:0]) : fast_raw;

    // -------------------------------------------------------------------------
    // One iteration of each datapath
    // -------------------------------------------------------------------------
    // Multiply walks the multiplier MSB-first (W operands are pre-shifted to
    // the top), so the product always ends right-aligned in prod.
    logic [2*XLEN-1:0] prod_step;
    logic [XLEN:0]     trial, diff;
    logic [XLEN-1:0]   rem_step, quo_step;

    assign prod_step = {prod_q[2*XLEN-2:0], 1'b0} +
                       (mb_q[XLEN-1] ? {{XLEN{1'b0}}, ma_q} : '0);

    assign trial    = {rem_q, mb_q[XLEN-1]};
    assign diff     = trial - {1'b0, ma_q};
    assign rem_step = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_step = {mb_q[XLEN-2:0], ~diff[XLEN]};

    // -------------------------------------------------------------------------
    // Sign fixup applied on the final iteration
    // -------------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;
    logic [XLEN-1:0]   mul_raw, div_raw, fin_raw, fin_res;

    assign prod_fix = (sa_q ^ sb_q) ? (-prod_step) : prod_step;
    assign quo_fix  = (sa_q ^ sb_q) ? (-quo_step)  : quo_step;
    assign rem_fix  = sa_q ? (-rem_step) : rem_step;

    // The only W multiply is MULW, so the high half is always the XLEN half.
    assign mul_raw = (f3_q == 3'b000) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    assign div_raw = f3_q[1] ? rem_fix : quo_fix;
    assign fin_raw = (state_q == ST_MUL) ? mul_raw : div_raw;
    assign fin_res = is_w_q ? sext32(fin_raw[31:0]) : fin_raw;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        counter_d      = counter_q;
        f3_d           = f3_q;
        is_w_d         = is_w_q;
        sa_d           = sa_q;
        sb_d           = sb_q;
        ma_d           = ma_q;
        mb_d           = mb_q;
        prod_d         = prod_q;
        rem_d          = rem_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    f3_d   = f3_in;
                    is_w_d = is_op32;
                    sa_d   = neg_a;
                    sb_d   = neg_b;
                    prod_d = '0;
                    rem_d  = '0;
                    if (f3_in[2]) begin
                        ma_d = mag_b;
                        mb_d = is_op32 ? (mag_a << 32) : mag_a;
                    end else begin
                        ma_d = mag_a;
                        mb_d = is_op32 ? (mag_b << 32) : mag_b;
                    end
                    if (fast) begin
                        state_d        = ST_DONE;
                        counter_d      = '0;
                        result_d       = fast_res;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d   = f3_in[2] ? ST_DIV : ST_MUL;
                        counter_d = is_op32 ? CNT_W'(32) : CNT_W'(XLEN);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_MUL, ST_DIV: begin
                counter_d = counter_q - CNT_W'(1);
                if (state_q == ST_MUL) begin
                    prod_d = prod_step;
                    mb_d   = mb_q << 1;
                end else begin
                    rem_d = rem_step;
                    mb_d  = quo_step;
                end
                if (counter_q == CNT_W'(1)) begin
                    state_d        = ST_DONE;
                    result_d       = fin_res;
                    result_valid_d = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

`ifdef MULDIV_FLUSH_EN
        // Flush wins over everything, including an accept in the same cycle.
        if (flush) begin
            state_d        = ST_IDLE;
            counter_d      = '0;
            result_d       = result_q;
            result_valid_d = 1'b0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            counter_q      <= '0;
            f3_q           <= '0;
            is_w_q         <= 1'b0;
            sa_q           <= 1'b0;
            sb_q           <= 1'b0;
            ma_q           <= '0;
            mb_q           <= '0;
            prod_q         <= '0;
            rem_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            counter_q      <= counter_d;
            f3_q           <= f3_d;
            is_w_q         <= is_w_d;
            sa_q           <= sa_d;
            sb_q           <= sb_d;
            ma_q           <= ma_d;
            mb_q           <= mb_d;
            prod_q         <= prod_d;
            rem_q          <= rem_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign busy         = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign stall_req    = busy || accept;
    assign result_valid = result_valid_q;
    assign result       = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;

    localparam logic [6:0]  OP    = 7'b0110011;
    localparam logic [6:0]  OP32  = 7'b0111011;
    localparam logic [6:0]  F7M   = 7'b0000001;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk          = 1'b0;
    logic        reset        = 1'b0;
    logic        start        = 1'b0;
`ifdef MULDIV_FLUSH_EN
    logic        flush        = 1'b0;
`endif
    logic [6:0]  alu_op_in    = 7'd0;
    logic [2:0]  alu_func3_in = 3'd0;
    logic [6:0]  alu_func7_in = 7'd0;
    logic [63:0] operand_a    = 64'd0;
    logic [63:0] operand_b    = 64'd0;
    logic        busy;
    logic        stall_req;
    logic        result_valid;
    logic [63:0] result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
`ifdef MULDIV_FLUSH_EN
        .flush        (flush),
`endif
        .alu_op_in    (alu_op_in),
        .alu_func3_in (alu_func3_in),
        .alu_func7_in (alu_func7_in),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .busy         (busy),
        .stall_req    (stall_req),
        .result_valid (result_valid),
        .result       (result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Reference: RISC-V M semantics straight from native arithmetic.
    function automatic logic [63:0] ref_model(input logic w, input logic [2:0] f3,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [63:0]         r;
        logic [127:0]        p;
        logic signed [127:0] pa, pb;
        logic signed [63:0]  sa64, sb64;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         a32, b32, r32;
        r = 64'd0;
        p = 128'd0;
        sa64 = a;
        sb64 = b;
        a32  = a[31:0];
        b32  = b[31:0];
        sa32 = a32;
        sb32 = b32;
        r32  = 32'd0;
        if (!w) begin
            case (f3)
                3'd0: r = a * b;
                3'd1: begin pa = sa64; pb = sb64; p = pa * pb; r = p[127:64]; end
                3'd2: begin pa = sa64; pb = {64'd0, b}; p = pa * pb; r = p[127:64]; end
                3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
                3'd4: begin
                    if (b == 0) r = ONES;
                    else if (a == MIN64 && b == ONES) r = MIN64;
                    else r = sa64 / sb64;
                end
                3'd5: begin
                    if (b == 0) r = ONES;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == MIN64 && b == ONES) r = 64'd0;
                    else r = sa64 % sb64;
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end else begin
            case (f3)
                3'd4: begin
                    if (b32 == 0) r32 = 32'hFFFF_FFFF;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 32'h8000_0000;
                    else r32 = sa32 / sb32;
                end
                3'd5: begin
                    if (b32 == 0) r32 = 32'hFFFF_FFFF;
                    else r32 = a32 / b32;
                end
                3'd6: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = 32'd0;
                    else r32 = sa32 % sb32;
                end
                3'd7: begin
                    if (b32 == 0) r32 = a32;
                    else r32 = a32 % b32;
                end
                default: r32 = a32 * b32;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    function automatic bit is_fast(input logic w, input logic [2:0] f3,
                                   input logic [63:0] a, input logic [63:0] b);
        bit sgn;
        sgn = (f3 == 3'd4) || (f3 == 3'd6);
        if (f3 < 3'd4) return 1'b0;
        if (w) return (b[31:0] == 0) ||
                      (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
        return (b == 0) || (sgn && a == MIN64 && b == ONES);
    endfunction

    task automatic drive(input logic w, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [63:0] a, input logic [63:0] b);
        alu_op_in    = w ? OP32 : OP;
        alu_func3_in = f3;
        alu_func7_in = f7;
        operand_a    = a;
        operand_b    = b;
        start        = 1'b1;
    endtask

    // Latency is counted in edges after the accept edge: N for iterating ops,
    // 0 for fast paths (pulse in the cycle right after the accept cycle).
    task automatic run_op(input logic w, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] b, input string tag);
        int          lat;
        int          exp_lat;
        logic [63:0] exp;
        exp     = ref_model(w, f3, a, b);
        exp_lat = is_fast(w, f3, a, b) ? 0 : (w ? 32 : 64);
        @(negedge clk);
        drive(w, f3, F7M, a, b);
        #1;
        check_eq({tag, "_stall"}, {63'd0, stall_req}, 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!result_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_res"}, result, exp);
        check_eq({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'($urandom_range(0, 10));
            1: v = -64'($urandom_range(1, 10));
            2: v = MIN64;
            3: v = ONES;
            4: v = {32'($urandom), 32'h8000_0000};
            5: v = {32'($urandom), 32'($urandom_range(0, 3))};
            default: v = {32'($urandom), 32'($urandom)};
        endcase
        return v;
    endfunction

    initial begin
        int          lat;
        int          pulses;
        logic        w;
        logic [2:0]  f3;
        logic [63:0] held;

        // Reset state
        #3;
        check_eq("rst_busy",  {63'd0, busy},         64'd0);
        check_eq("rst_valid", {63'd0, result_valid}, 64'd0);
        check_eq("rst_res",   result,                64'd0);
        check_eq("rst_stall", {63'd0, stall_req},    64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_op(1'b0, 3'd0, 64'd7, 64'd6, "mul7x6");
        check_eq("mul7x6_val", result, 64'd42);
        run_op(1'b0, 3'd1, ONES, ONES, "mulh");
        check_eq("mulh_val", result, 64'd0);
        run_op(1'b0, 3'd3, ONES, ONES, "mulhu");
        check_eq("mulhu_val", result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op(1'b0, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "div");
        check_eq("div_val", result, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b0, 3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "rem");
        check_eq("rem_val", result, ONES);
        run_op(1'b1, 3'd5, 64'h1_0000_0010, 64'd4, "divuw");
        check_eq("divuw_val", result, 64'd4);
        run_op(1'b0, 3'd4, 64'd5, 64'd0, "div0");
        check_eq("div0_val", result, ONES);
        run_op(1'b0, 3'd6, 64'd5, 64'd0, "rem0");
        check_eq("rem0_val", result, 64'd5);
        run_op(1'b0, 3'd4, MIN64, ONES, "divovf");
        check_eq("divovf_val", result, MIN64);
        run_op(1'b1, 3'd4, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, "divwovf");
        run_op(1'b1, 3'd0, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_0000_0002, "mulw");

        // Start while iterating is ignored; then a back-to-back accept in DONE
        @(negedge clk);
        drive(1'b0, 3'd0, F7M, 64'd7, 64'd6);
        @(posedge clk);
        #1;
        lat = 0;
        while (!result_valid && lat < 200) begin
            if (lat == 9) drive(1'b0, 3'd4, F7M, 64'd100, 64'd3);
            else start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
            if (lat == 10) check_eq("ign_busy", {63'd0, busy}, 64'd1);
        end
        start = 1'b0;
        check_eq("ign_lat", 64'(lat), 64'd64);
        check_eq("ign_res", result, 64'd42);
        run_op(1'b0, 3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, "b2b_div");

        // Non-M encodings are not accepted
        repeat (2) @(negedge clk);
        drive(1'b0, 3'd0, 7'd0, 64'd3, 64'd3);
        #1;
        check_eq("nonm_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        drive(1'b1, 3'd1, F7M, 64'd3, 64'd3);
        #1;
        check_eq("w_mulh_stall", {63'd0, stall_req}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        check_eq("nonm_busy", {63'd0, busy}, 64'd0);
        check_eq("nonm_valid", {63'd0, result_valid}, 64'd0);

        // Randomized operations, with occasional idle gaps
        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (w && f3 != 3'd0 && !f3[2]) f3 = 3'd0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            run_op(w, f3, rand_operand(), rand_operand(), "rnd");
        end

`ifdef MULDIV_FLUSH_EN
        // Flush mid-operation: IDLE at the next edge, no pulse, result held
        held = result;
        @(negedge clk);
        drive(1'b0, 3'd0, F7M, 64'd9, 64'd9);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check_eq("fl_busy", {63'd0, busy}, 64'd0);
        check_eq("fl_res", result, held);
        pulses = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        check_eq("fl_nopulse", 64'(pulses), 64'd0);
        // Flush beats a simultaneous accept
        @(negedge clk);
        drive(1'b0, 3'd4, F7M, 64'd5, 64'd0);
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check_eq("fl_acc_valid", {63'd0, result_valid}, 64'd0);
        check_eq("fl_acc_res", result, held);
`endif

        // Reset mid-divide aborts at once
        @(negedge clk);
        drive(1'b0, 3'd5, F7M, 64'd1000, 64'd7);
        @(posedge clk);
        #1;
        start = 1'b0;
        held = ref_model(1'b0, 3'd5, 64'd1000, 64'd7);
        repeat (20) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("arst_busy",  {63'd0, busy},         64'd0);
        check_eq("arst_res",   result,                64'd0);
        check_eq("arst_valid", {63'd0, result_valid}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        check_eq("arst_nopulse", 64'(pulses), 64'd0);
        run_op(1'b0, 3'd5, 64'd1000, 64'd7, "post_rst");
        check_eq("post_rst_val", result, held);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

endmodule
